sample_mgmt_mc: RTL and testbench

//  Multi-channel successor of the single-channel sample manager. Polls NUM_CH sample sources round-robin:

---
 rtl/sample_mgmt_pkg.sv | 22 ++
 rtl/sample_mgmt_chsel.sv | 41 ++++
 rtl/sample_mgmt_mc.sv | 142 ++++++++++++++
 tb/tb_sample_mgmt_mc.sv | 136 +++++++++++++
 4 files changed

// File: rtl/sample_mgmt_pkg.sv
// sample_mgmt_pkg: shared FSM state encoding and channel-index width helper
// for the multi-channel sample manager.
`default_nettype none

package sample_mgmt_pkg;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    VALID = 3'd3,
    TOUT  = 3'd4
  } state_t;

  // A channel index needs at least one bit even for degenerate channel counts
  function automatic int ch_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sample_mgmt_chsel.sv
// sample_mgmt_chsel: polled-channel index register with wrap flag and one-hot
// request decode. Rev 1.0.
`default_nettype none

module sample_mgmt_chsel
  import sample_mgmt_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        clear,
  input  logic                        advance,
  output logic [ch_width(NUM_CH)-1:0] ch,
  output logic                        wrap,
  output logic [NUM_CH-1:0]           onehot
);

  localparam int CH_W = ch_width(NUM_CH);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

  assign wrap = (ch == CH_LAST);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      ch <= '0;
    end else if (clear) begin
      ch <= '0;
    end else if (advance) begin
      ch <= wrap ? '0 : ch + CH_W'(1);
    end
  end

  always_comb begin
    onehot     = '0;
    onehot[ch] = 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/sample_mgmt_mc.sv
// sample_mgmt_mc: round-robin poller of NUM_CH sample sources with frame counter.
// Optional WAIT timeout enabled by defining SAMPLE_MGMT_TIMEOUT_EN. Rev 1.0.
`default_nettype none

module sample_mgmt_mc
  import sample_mgmt_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int CTR_WIDTH      = 24,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        i_clk,
  input  logic                        i_nrst,
  input  logic                        i_ce,
  input  logic                        i_new_record,
  input  logic [NUM_CH-1:0]           i_signal_valid,
  output logic [NUM_CH-1:0]           o_signal_req,
  output logic                        o_signal_valid,
  output logic [ch_width(NUM_CH)-1:0] o_ch,
  output logic [CTR_WIDTH-1:0]        o_ctr,
  output logic                        o_timeout
);

  localparam int CH_W = ch_width(NUM_CH);

  state_t                state;
  state_t                state_n;
  logic                  adv;
  logic                  clr;
  logic                  act;
  logic                  timeout_hit;
  logic [CH_W-1:0]       ch;
  logic                  wrap;
  logic [NUM_CH-1:0]     onehot;
  logic [CTR_WIDTH-1:0]  ctr;

  // A new record cancels whatever the current cycle would have produced
  assign act = i_ce & ~i_new_record;

  sample_mgmt_chsel #(
    .NUM_CH (NUM_CH)
  ) u_chsel (
    .clk     (i_clk),
    .nrst    (i_nrst),
    .clear   (i_ce & clr),
    .advance (i_ce & adv),
    .ch      (ch),
    .wrap    (wrap),
    .onehot  (onehot)
  );

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state <= INIT;
    end else if (i_ce) begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    adv     = 1'b0;
    clr     = 1'b0;
    case (state)
      INIT:  state_n = REQ;
      REQ:   state_n = WAIT;
      WAIT: begin
        if (i_signal_valid[ch]) begin
          state_n = VALID;
        end else if (timeout_hit) begin
          state_n = TOUT;
        end
      end
      VALID, TOUT: begin
        state_n = REQ;
        adv     = 1'b1;
      end
      default: state_n = INIT;
    endcase
    if (i_new_record) begin
      state_n = REQ;
      adv     = 1'b0;
      clr     = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      ctr            <= '0;
      o_signal_req   <= '0;
      o_signal_valid <= 1'b0;
      o_ch           <= '0;
      o_ctr          <= '0;
    end else begin
      o_signal_req   <= (act && state == REQ) ? onehot : '0;
      o_signal_valid <= act && (state == VALID);
      if (act && (state == VALID || state == TOUT)) begin
        o_ch  <= ch;
        o_ctr <= ctr;
      end
      if (i_ce && clr) begin
        ctr <= '0;
      end else if (i_ce && adv && wrap) begin
        ctr <= ctr + CTR_WIDTH'(1);
      end
    end
  end

`ifdef SAMPLE_MGMT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tcnt;

  assign timeout_hit = (tcnt == T_LAST);

  // Counts WAIT cycles since entry; cleared in any other state
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      tcnt      <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= act && (state == TOUT);
      if (i_ce) begin
        if (state != WAIT || i_new_record) begin
          tcnt <= '0;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout_hit = 1'b0;
  assign o_timeout   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sample_mgmt_mc.sv
// tb_sample_mgmt_mc: randomized stimulus against a poll-slot reference model.
`default_nettype none
`timescale 1ns/1ps

module tb_sample_mgmt_mc;

  localparam int NUM_CH    = 4;
  localparam int CTR_WIDTH = 3;
  localparam int T_CYC     = 8;
  localparam int N_CYCLES  = 4000;
`ifdef SAMPLE_MGMT_TIMEOUT_EN
  localparam bit TOUT_EN = 1'b1;
`else
  localparam bit TOUT_EN = 1'b0;
`endif

  logic                 clk;
  logic                 nrst;
  logic                 ce;
  logic                 new_record;
  logic [NUM_CH-1:0]    sig_valid;
  logic [NUM_CH-1:0]    sig_req;
  logic                 out_valid;
  logic [1:0]           out_ch;
  logic [CTR_WIDTH-1:0] out_ctr;
  logic                 out_tout;

  int total = 0;
  int bad   = 0;

  sample_mgmt_mc #(
    .NUM_CH         (NUM_CH),
    .CTR_WIDTH      (CTR_WIDTH),
    .TIMEOUT_CYCLES (T_CYC)
  ) dut (
    .i_clk          (clk),
    .i_nrst         (nrst),
    .i_ce           (ce),
    .i_new_record   (new_record),
    .i_signal_valid (sig_valid),
    .o_signal_req   (sig_req),
    .o_signal_valid (out_valid),
    .o_ch           (out_ch),
    .o_ctr          (out_ctr),
    .o_timeout      (out_tout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the poll cycle is a sequence of slots
  // (startup idle, request, listening, accept/timeout) over channel/frame numbers.
  typedef enum int {S_IDLE, S_ISSUE, S_LISTEN, S_ACCEPT, S_EXPIRE} slot_e;
  slot_e m_slot;
  int    m_ch, m_frame, m_listen;
  int    e_req, e_valid, e_tout, e_ch, e_ctr;

  task automatic model_edge();
    if (!nrst) begin
      m_slot = S_IDLE; m_ch = 0; m_frame = 0; m_listen = 0;
      e_req = 0; e_valid = 0; e_tout = 0; e_ch = 0; e_ctr = 0;
      return;
    end
    e_req = 0; e_valid = 0; e_tout = 0;
    if (!ce) return;
    if (new_record) begin
      m_slot = S_ISSUE; m_ch = 0; m_frame = 0; m_listen = 0;
      return;
    end
    case (m_slot)
      S_IDLE:  m_slot = S_ISSUE;
      S_ISSUE: begin
        e_req    = 1 << m_ch;
        m_slot   = S_LISTEN;
        m_listen = 0;
      end
      S_LISTEN: begin
        if (sig_valid[m_ch]) m_slot = S_ACCEPT;
        else if (TOUT_EN && m_listen == T_CYC - 1) m_slot = S_EXPIRE;
        else m_listen++;
      end
      default: begin
        if (m_slot == S_ACCEPT) e_valid = 1; else e_tout = 1;
        e_ch  = m_ch;
        e_ctr = m_frame;
        m_ch  = (m_ch + 1) % NUM_CH;
        if (m_ch == 0) m_frame = (m_frame + 1) % (1 << CTR_WIDTH);
        m_slot = S_ISSUE;
      end
    endcase
  endtask

  task automatic compare_all();
    check("req",     int'(sig_req),   e_req);
    check("valid",   int'(out_valid), e_valid);
    check("timeout", int'(out_tout),  e_tout);
    check("ch",      int'(out_ch),    e_ch);
    check("ctr",     int'(out_ctr),   e_ctr);
  endtask

  initial begin
    nrst = 1'b0; ce = 1'b1; new_record = 1'b0; sig_valid = '0;
    m_slot = S_IDLE; m_ch = 0; m_frame = 0; m_listen = 0;
    e_req = 0; e_valid = 0; e_tout = 0; e_ch = 0; e_ctr = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      model_edge();
      compare_all();
    end
    nrst = 1'b1;
    for (int i = 0; i < N_CYCLES; i++) begin
      @(posedge clk); #1;
      model_edge();
      compare_all();
      nrst       = ($urandom_range(999) >= 3);
      ce         = ($urandom_range(99) < 85);
      new_record = ($urandom_range(99) < 1);
      for (int b = 0; b < NUM_CH; b++) sig_valid[b] = ($urandom_range(99) < 30);
      // Occasionally silence all sources to exercise long waits and timeouts
      if ((i / 200) % 4 == 3 && ($urandom_range(9) < 9)) sig_valid = '0;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
